scc_tone_counter: RTL and testbench

Time-multiplexed tone sequencer for the five-channel wave table sound block. It generates the `active` channel-slot index that drives the register file's parameter selectors, and consumes the selected 12-bit frequency value, the per-channel counter-clear strobes and the wave-reset mode. For each channel it runs a 12-bit period down-counter and a 5-bit waveform pointer, and issues one wave-memory read request per channel slot toward the wave RAM and mixer stage.

---
 rtl/scc_tone_counter.sv | 184 ++++++++++++++++++
 tb/tb_scc_tone_counter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scc_tone_counter.sv
// scc_tone_counter
// Time-multiplexed tone sequencer for a five-channel wave table sound block.
// The block steps through six slots (channels A..E plus one idle slot). On the
// enable tick after a channel's slot is shown on `active`, it processes that
// channel together with the frequency register selected by that slot. Each
// channel has a 12-bit period down-counter and a 5-bit waveform pointer. Every
// channel service issues one wave-memory read request.
module scc_tone_counter #(
    parameter int MIN_FREQ = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [2:0]  active,
    input  logic [11:0] reg_frequency_count0,
    input  logic        reg_wave_reset,
    input  logic        clear_counter_a0,
    input  logic        clear_counter_b0,
    input  logic        clear_counter_c0,
    input  logic        clear_counter_d0,
    input  logic        clear_counter_e0,
    output logic        wave_read,
    output logic [2:0]  wave_id,
    output logic [4:0]  wave_address
);

    localparam int          NCH       = 5;
    localparam logic [2:0]  IDLE_SLOT = 3'd5;
    localparam logic [11:0] MIN_F     = 12'(MIN_FREQ);

    // Slot that follows s in the repeating order 0,1,2,3,4,5,0...
    function automatic logic [2:0] slot_after(input logic [2:0] s);
        return (s >= IDLE_SLOT) ? 3'd0 : s + 3'd1;
    endfunction

    // Slot sequencer and the one-tick-late copy of the slot, which lines up
    // with the frequency value the register file returns for it.
    logic [2:0] active_q;
    logic [2:0] active_d;
    logic [2:0] slot_q;

    // Per-channel tone state.
    logic [11:0]    cnt_q [NCH];
    logic [4:0]     ptr_q [NCH];
    logic [NCH-1:0] rpend_q;
    logic [NCH-1:0] rpend_d;
    logic [NCH-1:0] ppend_q;
    logic [NCH-1:0] ppend_d;

    // Request output registers.
    logic           wave_read_q;
    logic [2:0]     wave_id_q;
    logic [4:0]     wave_address_q;

    // Decode of the current tick.
    logic [NCH-1:0] clr;
    logic           proc;
    logic [NCH-1:0] svc;
    logic [11:0]    cur_cnt;
    logic [4:0]     cur_ptr;
    logic           cur_rp;
    logic           cur_pp;
    logic [11:0]    cnt_d;
    logic [4:0]     ptr_d;

    assign clr = {clear_counter_e0, clear_counter_d0, clear_counter_c0,
                  clear_counter_b0, clear_counter_a0};

    // A channel is processed only on an enable tick whose delayed slot is a
    // real channel; the idle slot does nothing.
    assign proc = enable && (slot_q < IDLE_SLOT);

    // Next slot to show on `active`.
    always_comb begin
        active_d = slot_after(active_q);
    end

    // Slot sequencer: advance `active` and its delayed copy on every tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 3'd0;
            slot_q   <= IDLE_SLOT;
        end else if (enable) begin
            active_q <= active_d;
            slot_q   <= active_q;
        end
    end

    // Select the state of the channel being serviced and flag it one-hot.
    always_comb begin
        cur_cnt = '0;
        cur_ptr = '0;
        cur_rp  = 1'b0;
        cur_pp  = 1'b0;
        svc     = '0;
        for (int c = 0; c < NCH; c++) begin
            if (slot_q == 3'(c)) begin
                cur_cnt = cnt_q[c];
                cur_ptr = ptr_q[c];
                cur_rp  = rpend_q[c];
                cur_pp  = ppend_q[c];
                svc[c]  = proc;
            end
        end
    end

    // Service rules in priority order: pending reload, frozen below the
    // minimum frequency, period expiry with pointer step, plain countdown.
    always_comb begin
        cnt_d = cur_cnt;
        ptr_d = cur_ptr;
        if (cur_rp) begin
            cnt_d = reg_frequency_count0;
            if (cur_pp) begin
                ptr_d = 5'd0;
            end
        end else if (reg_frequency_count0 < MIN_F) begin
            cnt_d = cur_cnt;
            ptr_d = cur_ptr;
        end else if (cur_cnt == 12'd0) begin
            cnt_d = reg_frequency_count0;
            ptr_d = cur_ptr + 5'd1;
        end else begin
            cnt_d = cur_cnt - 12'd1;
        end
    end

    // Pending flags: a service consumes the flags it saw, while a strobe in
    // the same clk is captured afresh so it lands on the following service.
    always_comb begin
        rpend_d = (rpend_q & ~svc) | clr;
        ppend_d = (ppend_q & ~svc) | (clr & {NCH{reg_wave_reset}});
    end

    // Pending flags are sampled on every clk, independent of enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            rpend_q <= '0;
            ppend_q <= '0;
        end else begin
            rpend_q <= rpend_d;
            ppend_q <= ppend_d;
        end
    end

    // Write back the serviced channel's counter and pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                cnt_q[c] <= '0;
                ptr_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (svc[c]) begin
                    cnt_q[c] <= cnt_d;
                    ptr_q[c] <= ptr_d;
                end
            end
        end
    end

    // Read request: one-clk pulse carrying the freshly updated pointer; the
    // id/address hold between requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            wave_read_q    <= 1'b0;
            wave_id_q      <= 3'd0;
            wave_address_q <= 5'd0;
        end else begin
            wave_read_q <= proc;
            if (proc) begin
                wave_id_q      <= slot_q;
                wave_address_q <= ptr_d;
            end
        end
    end

    assign active       = active_q;
    assign wave_read    = wave_read_q;
    assign wave_id      = wave_id_q;
    assign wave_address = wave_address_q;

endmodule

// File: tb/tb_scc_tone_counter.sv
// Self-checking bench for scc_tone_counter. A small behavioural model runs
// alongside the DUT; each request it predicts is queued and matched against
// the DUT's wave_read pulses. Directed checks cover the scenario end points.
module tb_scc_tone_counter;

    localparam int MIN_FREQ = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [2:0]  active;
    logic [11:0] reg_frequency_count0;
    logic        reg_wave_reset;
    logic        clear_counter_a0;
    logic        clear_counter_b0;
    logic        clear_counter_c0;
    logic        clear_counter_d0;
    logic        clear_counter_e0;
    logic        wave_read;
    logic [2:0]  wave_id;
    logic [4:0]  wave_address;

    always #5 clk = ~clk;

    scc_tone_counter #(.MIN_FREQ(MIN_FREQ)) dut (
        .clk                  (clk),
        .reset                (reset),
        .enable               (enable),
        .active               (active),
        .reg_frequency_count0 (reg_frequency_count0),
        .reg_wave_reset       (reg_wave_reset),
        .clear_counter_a0     (clear_counter_a0),
        .clear_counter_b0     (clear_counter_b0),
        .clear_counter_c0     (clear_counter_c0),
        .clear_counter_d0     (clear_counter_d0),
        .clear_counter_e0     (clear_counter_e0),
        .wave_read            (wave_read),
        .wave_id              (wave_id),
        .wave_address         (wave_address)
    );

    typedef struct {
        int id;
        int addr;
    } req_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    req_t sb[$];

    // Reference model state.
    int   m_active;
    int   m_slot;
    int   m_cnt [5];
    int   m_ptr [5];
    bit   m_rp  [5];
    bit   m_pp  [5];
    bit   exp_read;

    int   freq [5];
    int   last_addr [5];
    bit   gap_mode;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit en, input bit rst, input bit [4:0] clr, input bit wr);
        int   x;
        int   fv;
        req_t r;
        exp_read = 1'b0;
        if (rst) begin
            m_active = 0;
            m_slot   = 5;
            for (int c = 0; c < 5; c++) begin
                m_cnt[c] = 0;
                m_ptr[c] = 0;
                m_rp[c]  = 1'b0;
                m_pp[c]  = 1'b0;
            end
        end else begin
            if (en) begin
                if (m_slot < 5) begin
                    x  = m_slot;
                    fv = freq[x];
                    if (m_rp[x]) begin
                        m_cnt[x] = fv;
                        if (m_pp[x]) m_ptr[x] = 0;
                        m_rp[x] = 1'b0;
                        m_pp[x] = 1'b0;
                    end else if (fv < MIN_FREQ) begin
                        m_cnt[x] = m_cnt[x];
                    end else if (m_cnt[x] == 0) begin
                        m_cnt[x] = fv;
                        m_ptr[x] = (m_ptr[x] + 1) % 32;
                    end else begin
                        m_cnt[x] = m_cnt[x] - 1;
                    end
                    exp_read = 1'b1;
                    r.id   = x;
                    r.addr = m_ptr[x];
                    sb.push_back(r);
                end
                m_slot   = m_active;
                m_active = (m_active == 5) ? 0 : m_active + 1;
            end
            for (int c = 0; c < 5; c++) begin
                if (clr[c]) begin
                    m_rp[c] = 1'b1;
                    if (wr) m_pp[c] = 1'b1;
                end
            end
        end
    endtask

    // One clk: drive on the falling edge, step the model, check after the rise.
    task automatic clk_edge(input bit en, input bit rst, input bit [4:0] clr, input bit wr);
        req_t r;
        @(negedge clk);
        reset            = rst;
        enable           = en;
        reg_wave_reset   = wr;
        clear_counter_a0 = clr[0];
        clear_counter_b0 = clr[1];
        clear_counter_c0 = clr[2];
        clear_counter_d0 = clr[3];
        clear_counter_e0 = clr[4];
        reg_frequency_count0 = (m_slot < 5) ? 12'(freq[m_slot]) : 12'd0;
        model_step(en, rst, clr, wr);
        @(posedge clk);
        #1;
        check_eq("wave_read", 32'(wave_read), 32'(exp_read));
        if (wave_read === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                r = sb.pop_front();
                check_eq("wave_id", 32'(wave_id), r.id);
                check_eq("wave_address", 32'(wave_address), r.addr);
            end
            if (wave_id < 3'd5) last_addr[int'(wave_id)] = int'(wave_address);
        end else begin
            sb.delete();
        end
        if (en && !rst) check_eq("active", 32'(active), m_active);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            if (gap_mode) begin
                for (int g = int'($urandom_range(0, 2)); g > 0; g--) clk_edge(1'b0, 1'b0, 5'd0, 1'b0);
            end
            clk_edge(1'b1, 1'b0, 5'd0, 1'b0);
        end
    endtask

    task automatic do_reset();
        clk_edge(1'b0, 1'b1, 5'd0, 1'b0);
        clk_edge(1'b0, 1'b1, 5'd0, 1'b0);
        check_eq("rst_active", 32'(active), 32'd0);
        check_eq("rst_wave_read", 32'(wave_read), 32'd0);
        check_eq("rst_wave_id", 32'(wave_id), 32'd0);
        check_eq("rst_wave_address", 32'(wave_address), 32'd0);
        for (int c = 0; c < 5; c++) last_addr[c] = -1;
    endtask

    task automatic set_freq(input int fa, input int fb, input int fc, input int fd, input int fe);
        freq[0] = fa; freq[1] = fb; freq[2] = fc; freq[3] = fd; freq[4] = fe;
    endtask

    initial begin
        int guard;
        reset = 1'b1; enable = 1'b0; reg_wave_reset = 1'b0;
        reg_frequency_count0 = 12'd0;
        clear_counter_a0 = 1'b0; clear_counter_b0 = 1'b0; clear_counter_c0 = 1'b0;
        clear_counter_d0 = 1'b0; clear_counter_e0 = 1'b0;
        gap_mode = 1'b0;
        set_freq(0, 0, 0, 0, 0);
        model_step(1'b0, 1'b1, 5'd0, 1'b0);

        // All frequencies zero: slot order and idle-slot silence.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check_eq("active_seq", 32'(active), (i + 1) % 6);
        end
        for (int c = 0; c < 5; c++) check_eq("zero_freq_addr", last_addr[c], 0);

        // Channel A at F=9 for 600 ticks, with enable gaps.
        gap_mode = 1'b1;
        do_reset();
        set_freq(9, 0, 0, 0, 0);
        tick(600);
        check_eq("a_600_ticks", last_addr[0], 10);
        for (int c = 1; c < 5; c++) check_eq("others_idle", last_addr[c], 0);

        // Channel C below the minimum frequency stays frozen.
        do_reset();
        set_freq(0, 0, 8, 0, 0);
        tick(1000);
        check_eq("c_frozen", last_addr[2], 0);
        set_freq(0, 0, 9, 0, 0);
        tick(6);
        check_eq("c_unfrozen", last_addr[2], 1);
        gap_mode = 1'b0;

        // Counter clear on A with and without pointer rewind.
        do_reset();
        set_freq(9, 0, 0, 0, 0);
        guard = 0;
        while (m_ptr[0] != 17 && guard < 1500) begin
            tick(1);
            guard++;
        end
        check_eq("a_reach_17", last_addr[0], 17);
        clk_edge(1'b0, 1'b0, 5'b00001, 1'b0);
        tick(6);
        check_eq("a_clr_keep_ptr", last_addr[0], 17);
        clk_edge(1'b0, 1'b0, 5'b00001, 1'b1);
        tick(6);
        check_eq("a_clr_rewind", last_addr[0], 0);
        tick(54);
        check_eq("a_reload_hold", last_addr[0], 0);
        tick(6);
        check_eq("a_reload_step", last_addr[0], 1);

        // Strobe on B in the very clk that B is serviced.
        do_reset();
        set_freq(0, 9, 0, 0, 0);
        tick(130);
        guard = 0;
        while (m_slot != 1 && guard < 10) begin
            tick(1);
            guard++;
        end
        clk_edge(1'b1, 1'b0, 5'b00010, 1'b1);
        check_eq("b_same_clk_id", 32'(wave_id), 32'd1);
        check_eq("b_same_clk_unaffected", 32'(wave_address != 5'd0), 32'd1);
        tick(6);
        check_eq("b_next_rewind", last_addr[1], 0);

        // Pointer wrap 31 -> 0.
        do_reset();
        set_freq(9, 0, 0, 0, 0);
        guard = 0;
        while (!(m_ptr[0] == 31 && m_cnt[0] == 0) && guard < 2500) begin
            tick(1);
            guard++;
        end
        check_eq("a_at_31", last_addr[0], 31);
        tick(6);
        check_eq("a_wrap", last_addr[0], 0);

        // Reset with pending flags set discards them.
        set_freq(9, 9, 9, 9, 9);
        tick(20);
        clk_edge(1'b0, 1'b0, 5'b11111, 1'b1);
        do_reset();
        tick(12);
        for (int c = 0; c < 5; c++) check_eq("post_reset_no_pending", last_addr[c], 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
